// File: rtl/fetch_unit.sv
// Fetch-stage PC generator feeding the IF/ID register.
// Selects the next PC by priority: redirect > stall > predicted target > PC+4.
// Define BRANCH_PREDICT_EN to build the direct-mapped BTB with 2-bit counters;
// without it, Predict_Taken_F is tied low and the Update_* inputs are ignored.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Stall_En,
    input  logic        Redirect_En,
    input  logic [31:0] Redirect_PC,
    input  logic        Update_En,
    input  logic [31:0] Update_PC,
    input  logic [31:0] Update_Target,
    input  logic        Update_Taken,
    output logic [31:0] Imem_Addr,
    output logic [31:0] PC_F,
    output logic [31:0] PC_Plus_4_F,
    output logic        Predict_Taken_F,
    output logic        Valid_F
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    localparam logic ST_WARMUP = 1'b0;
    localparam logic ST_RUN    = 1'b1;

    logic        state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus_4;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic [31:0] redirect_aligned;

    assign pc_plus_4        = pc_q + 32'd4;
    assign redirect_aligned = {Redirect_PC[31:2], 2'b00};

`ifdef BRANCH_PREDICT_EN
    logic             btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
    logic [31:0]      btb_target [BTB_ENTRIES];
    logic [1:0]       btb_ctr    [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit;
    logic [31:0]      up_target_aligned;
    logic [1:0]       unused_low_bits;

    assign lk_idx            = pc_q[IDX_W+1:2];
    assign lk_tag            = pc_q[31:IDX_W+2];
    assign up_idx            = Update_PC[IDX_W+1:2];
    assign up_tag            = Update_PC[31:IDX_W+2];
    assign up_hit            = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);
    assign up_target_aligned = {Update_Target[31:2], 2'b00};
    assign unused_low_bits   = Update_PC[1:0] ^ Update_Target[1:0] ^ Redirect_PC[1:0];

    // Lookup reads the pre-update contents, so a same-edge update is not seen.
    always_comb begin
        predict_taken  = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag) && btb_ctr[lk_idx][1];
        predict_target = btb_target[lk_idx];
    end

    // BTB training from Execute: counter update on hit, allocate on taken miss.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= 2'b00;
            end
        end else if (Update_En) begin
            if (up_hit) begin
                if (Update_Taken) begin
                    btb_target[up_idx] <= up_target_aligned;
                    if (btb_ctr[up_idx] != 2'b11) btb_ctr[up_idx] <= btb_ctr[up_idx] + 2'd1;
                end else if (btb_ctr[up_idx] != 2'b00) begin
                    btb_ctr[up_idx] <= btb_ctr[up_idx] - 2'd1;
                end
            end else if (Update_Taken) begin
                btb_valid[up_idx]  <= 1'b1;
                btb_tag[up_idx]    <= up_tag;
                btb_target[up_idx] <= up_target_aligned;
                btb_ctr[up_idx]    <= 2'b10;
            end
        end
    end
`else
    logic unused_update;

    assign unused_update  = ^{Update_En, Update_PC, Update_Target, Update_Taken,
                              Redirect_PC[1:0]};
    assign predict_taken  = 1'b0;
    assign predict_target = 32'h0000_0000;
`endif

    // Next-state and next-PC selection; WARMUP holds the PC unless redirected.
    always_comb begin
        state_d = ST_RUN;
        pc_d    = pc_q;
        if (Redirect_En) begin
            pc_d = redirect_aligned;
        end else if (state_q == ST_WARMUP || Stall_En) begin
            pc_d = pc_q;
        end else if (predict_taken) begin
            pc_d = predict_target;
        end else begin
            pc_d = pc_plus_4;
        end
    end

    // PC and FSM registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_WARMUP;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Outputs to IF/ID and instruction memory.
    always_comb begin
        PC_F            = pc_q;
        Imem_Addr       = pc_q;
        PC_Plus_4_F     = pc_plus_4;
        Predict_Taken_F = predict_taken;
        Valid_F         = (state_q == ST_RUN);
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default parameters).
// BTB training/aliasing checks apply when BRANCH_PREDICT_EN is defined;
// otherwise the macro-off behaviour is checked instead.
module tb_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        Stall_En;
    logic        Redirect_En;
    logic [31:0] Redirect_PC;
    logic        Update_En;
    logic [31:0] Update_PC;
    logic [31:0] Update_Target;
    logic        Update_Taken;
    logic [31:0] Imem_Addr;
    logic [31:0] PC_F;
    logic [31:0] PC_Plus_4_F;
    logic        Predict_Taken_F;
    logic        Valid_F;

    int tests_run;
    int tests_failed;

    fetch_unit dut (
        .CLK             (CLK),
        .RST             (RST),
        .Stall_En        (Stall_En),
        .Redirect_En     (Redirect_En),
        .Redirect_PC     (Redirect_PC),
        .Update_En       (Update_En),
        .Update_PC       (Update_PC),
        .Update_Target   (Update_Target),
        .Update_Taken    (Update_Taken),
        .Imem_Addr       (Imem_Addr),
        .PC_F            (PC_F),
        .PC_Plus_4_F     (PC_Plus_4_F),
        .Predict_Taken_F (Predict_Taken_F),
        .Valid_F         (Valid_F)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        Stall_En      = 1'b0;
        Redirect_En   = 1'b0;
        Redirect_PC   = 32'h0;
        Update_En     = 1'b0;
        Update_PC     = 32'h0;
        Update_Target = 32'h0;
        Update_Taken  = 1'b0;
    endtask

    // Reset for two cycles, release at a falling edge; DUT is then in WARMUP.
    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        clear_inputs();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        @(negedge CLK);
        Redirect_En = 1'b1;
        Redirect_PC = target;
        tick();
        @(negedge CLK);
        Redirect_En = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b0;
        clear_inputs();
        @(negedge CLK);
        #1;
        tests_run++;
        if (PC_F !== 32'h0 || Imem_Addr !== 32'h0 || PC_Plus_4_F !== 32'h4 ||
            Valid_F !== 1'b0 || Predict_Taken_F !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: pc=%h imem=%h pc4=%h valid=%b pred=%b expected 0/0/4/0/0",
                     PC_F, Imem_Addr, PC_Plus_4_F, Valid_F, Predict_Taken_F);
        end
        @(negedge CLK);
        RST = 1'b1;
        #1;
        tests_run++;
        if (Valid_F !== 1'b0) begin
            tests_failed++;
            $display("FAIL warmup_valid: got %b expected 0", Valid_F);
        end
        tick();
        tests_run++;
        if (PC_F !== 32'h0 || Valid_F !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_run_edge: pc=%h valid=%b expected 0/1", PC_F, Valid_F);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            tests_run++;
            if (PC_F !== 32'(4 * i)) begin
                tests_failed++;
                $display("FAIL seq_pc%0d: got %h expected %h", i, PC_F, 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall_vs_redirect();
        redirect_to(32'h13);
        tests_run++;
        if (PC_F !== 32'h10) begin
            tests_failed++;
            $display("FAIL redirect_align: got %h expected 00000010", PC_F);
        end
        Stall_En = 1'b1;
        tick();
        tick();
        tests_run++;
        if (PC_F !== 32'h10) begin
            tests_failed++;
            $display("FAIL stall_hold: got %h expected 00000010", PC_F);
        end
        @(negedge CLK);
        Redirect_En = 1'b1;
        Redirect_PC = 32'h203;
        tick();
        tests_run++;
        if (PC_F !== 32'h200) begin
            tests_failed++;
            $display("FAIL redirect_over_stall: got %h expected 00000200", PC_F);
        end
        @(negedge CLK);
        Redirect_En = 1'b0;
        Stall_En    = 1'b0;
        tick();
        tests_run++;
        if (PC_F !== 32'h204) begin
            tests_failed++;
            $display("FAIL after_stall: got %h expected 00000204", PC_F);
        end
    endtask

    task automatic test_wrap();
        redirect_to(32'hFFFF_FFFC);
        tests_run++;
        if (PC_F !== 32'hFFFF_FFFC || PC_Plus_4_F !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_pc4: pc=%h pc4=%h expected fffffffc/00000000", PC_F, PC_Plus_4_F);
        end
        tick();
        tests_run++;
        if (PC_F !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_next: got %h expected 00000000", PC_F);
        end
    endtask

    task automatic test_warmup_redirect();
        do_reset();
        Redirect_En = 1'b1;
        Redirect_PC = 32'h80;
        tick();
        tests_run++;
        if (PC_F !== 32'h80 || Valid_F !== 1'b1) begin
            tests_failed++;
            $display("FAIL warmup_redirect: pc=%h valid=%b expected 00000080/1", PC_F, Valid_F);
        end
        @(negedge CLK);
        Redirect_En = 1'b0;
        tick();
        tests_run++;
        if (PC_F !== 32'h84) begin
            tests_failed++;
            $display("FAIL warmup_redirect_next: got %h expected 00000084", PC_F);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge CLK);
        Redirect_En = 1'b1;
        Redirect_PC = 32'h500;
        #2;
        RST = 1'b0;
        #1;
        tests_run++;
        if (PC_F !== 32'h0 || Valid_F !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: pc=%h valid=%b expected 0/0", PC_F, Valid_F);
        end
        tick();
        tests_run++;
        if (PC_F !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_discards_redirect: got %h expected 00000000", PC_F);
        end
        @(negedge CLK);
        clear_inputs();
        RST = 1'b1;
        tick();
        tick();
        tests_run++;
        if (PC_F !== 32'h4 || Valid_F !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_run: pc=%h valid=%b expected 4/1", PC_F, Valid_F);
        end
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        @(negedge CLK);
        Update_En     = 1'b1;
        Update_PC     = pc;
        Update_Target = tgt;
        Update_Taken  = taken;
        tick();
        @(negedge CLK);
        Update_En = 1'b0;
    endtask

`ifdef BRANCH_PREDICT_EN
    task automatic test_btb_train();
        do_reset();
        tick();
        train(32'h40, 32'h100, 1'b1);
        redirect_to(32'h40);
        tests_run++;
        if (Predict_Taken_F !== 1'b1) begin
            tests_failed++;
            $display("FAIL btb_predict: got %b expected 1", Predict_Taken_F);
        end
        tick();
        tests_run++;
        if (PC_F !== 32'h100) begin
            tests_failed++;
            $display("FAIL btb_target: got %h expected 00000100", PC_F);
        end
        train(32'h40, 32'h100, 1'b0);
        train(32'h40, 32'h100, 1'b0);
        redirect_to(32'h40);
        tests_run++;
        if (Predict_Taken_F !== 1'b0) begin
            tests_failed++;
            $display("FAIL btb_untrain: got %b expected 0", Predict_Taken_F);
        end
        tick();
        tests_run++;
        if (PC_F !== 32'h44) begin
            tests_failed++;
            $display("FAIL btb_untrain_next: got %h expected 00000044", PC_F);
        end
    endtask

    task automatic test_btb_alias();
        do_reset();
        tick();
        train(32'h40, 32'h100, 1'b1);
        train(32'h80, 32'h300, 1'b1);
        redirect_to(32'h40);
        tests_run++;
        if (Predict_Taken_F !== 1'b0) begin
            tests_failed++;
            $display("FAIL alias_evict: got %b expected 0", Predict_Taken_F);
        end
        redirect_to(32'h80);
        tests_run++;
        if (Predict_Taken_F !== 1'b1) begin
            tests_failed++;
            $display("FAIL alias_new: got %b expected 1", Predict_Taken_F);
        end
        tick();
        tests_run++;
        if (PC_F !== 32'h300) begin
            tests_failed++;
            $display("FAIL alias_target: got %h expected 00000300", PC_F);
        end
    endtask
`else
    task automatic test_macro_off();
        do_reset();
        tick();
        train(32'h40, 32'h100, 1'b1);
        redirect_to(32'h40);
        tests_run++;
        if (Predict_Taken_F !== 1'b0) begin
            tests_failed++;
            $display("FAIL nobtb_predict: got %b expected 0", Predict_Taken_F);
        end
        tick();
        tests_run++;
        if (PC_F !== 32'h44) begin
            tests_failed++;
            $display("FAIL nobtb_next: got %h expected 00000044", PC_F);
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        RST          = 1'b0;
        clear_inputs();
        test_reset();
        test_stall_vs_redirect();
        test_wrap();
        test_warmup_redirect();
        test_mid_reset();
`ifdef BRANCH_PREDICT_EN
        test_btb_train();
        test_btb_alias();
`else
        test_macro_off();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
